// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue sequencer (IDLE/DECODE/EXEC/WB) for a
// small RV32I subset. It latches one instruction, reads the register file,
// drives the ALU, then emits either a register write-back or a branch
// decision. Unsupported words produce a single-cycle illegal pulse.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        br_valid,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_B  = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded view of the latched instruction word.
  typedef struct packed {
    logic       legal;
    logic       is_br;
    logic       is_bne;
    logic       use_imm;
    logic [3:0] op;
  } dec_t;

  logic [1:0]  state, state_nxt;
  logic [31:0] instr_q, pc_q;
  logic        is_br_q, is_bne_q;
  logic [4:0]  rd_q;
  dec_t        dec;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_b, br_sum;
  logic        accept;

  assign opc = instr_q[6:0];
  assign f3  = instr_q[14:12];
  assign f7  = instr_q[31:25];

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid & instr_ready;

  // Register file addresses come straight from the latched word.
  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];

  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                   instr_q[30:25], instr_q[11:8], 1'b0};
  // Branch target has its own adder so the ALU stays free for the compare.
  assign br_sum = pc_q + imm_b;

  // Decode the supported subset; everything else stays illegal.
  always_comb begin
    dec    = '0;
    dec.op = OP_ADD;
    case (opc)
      OPC_R: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  begin dec.legal = 1'b1; dec.op = OP_ADD; end
            3'b111:  begin dec.legal = 1'b1; dec.op = OP_AND; end
            3'b110:  begin dec.legal = 1'b1; dec.op = OP_OR;  end
            default: dec.legal = 1'b0;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec.legal = 1'b1;
          dec.op    = OP_SUB;
        end
      end
      OPC_I: begin
        dec.use_imm = 1'b1;
        case (f3)
          3'b000:  begin dec.legal = 1'b1; dec.op = OP_ADD; end
          3'b111:  begin dec.legal = 1'b1; dec.op = OP_AND; end
          3'b110:  begin dec.legal = 1'b1; dec.op = OP_OR;  end
          default: dec.legal = 1'b0;
        endcase
      end
      OPC_B: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          dec.legal  = 1'b1;
          dec.is_br  = 1'b1;
          dec.is_bne = f3[0];
          dec.op     = OP_SUB;
        end
      end
      default: dec = '0;
    endcase
  end

  // Next-state logic: illegal words skip straight back to IDLE from DECODE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DECODE;
      DECODE:  state_nxt = dec.legal ? EXEC : IDLE;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the instruction word and its pc on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (accept) begin
      instr_q <= instr;
      pc_q    <= pc;
    end
  end

  // End of DECODE: register ALU operands, opcode, class and destination.
  // Operands are left untouched on an illegal word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      is_br_q  <= 1'b0;
      is_bne_q <= 1'b0;
      rd_q     <= '0;
    end else if (state == DECODE && dec.legal) begin
      alu_a    <= rs1_data;
      alu_b    <= dec.use_imm ? imm_i : rs2_data;
      alu_op   <= dec.op;
      is_br_q  <= dec.is_br;
      is_bne_q <= dec.is_bne;
      rd_q     <= instr_q[11:7];
    end
  end

  // Illegal pulse lands in the cycle where the block is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= (state == DECODE) && !dec.legal;
  end

  // End of EXEC: capture ALU outcome into the write-back / branch outputs,
  // which are then presented during WB and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_we     <= 1'b0;
      rd_addr   <= '0;
      rd_wdata  <= '0;
      br_valid  <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else begin
      rd_we    <= (state == EXEC) && !is_br_q && (rd_q != 5'd0);
      br_valid <= (state == EXEC) && is_br_q;
      if (state == EXEC && !is_br_q) begin
        rd_addr  <= rd_q;
        rd_wdata <= alu_result;
      end
      if (state == EXEC && is_br_q) begin
        br_taken  <= alu_zero ^ is_bne_q;
        br_target <= br_sum;
      end
    end
  end

  // At most one completion pulse per cycle, and never a write to x0.
  a_pulse_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({rd_we, br_valid, illegal}));
  a_no_x0_write: assert property (@(posedge clk) disable iff (rst)
    rd_we |-> (rd_addr != 5'd0));

endmodule
